// File: rtl/control_unit_fsm_if.sv
// Bundle between the multicycle control unit and the datapath: IR fields and
// ALU/mult-div status in, mux selects and register enables out.
interface control_unit_fsm_if #(
   parameter int EXC_ADDR_WIDTH = 32
);
   logic [5:0]                opcode;
   logic [5:0]                funct;
   logic                      overflowflag;
   logic                      zeroflag;
   logic                      gtflag;
   logic                      divby0flag;
   logic                      md_done;
   logic                      PCWrite;
   logic [1:0]                IorD;
   logic                      WR;
   logic                      IRWrite;
   logic                      RegWrite;
   logic [1:0]                RegDest;
   logic [2:0]                MemToReg;
   logic                      ALUSrcA;
   logic [1:0]                ALUSrcB;
   logic [2:0]                ControlType;
   logic                      AluOutLoad;
   logic [2:0]                PCSource;
   logic                      EPCWrite;
   logic                      md_start;
   logic                      md_sel;
   logic [EXC_ADDR_WIDTH-1:0] ExceptionAdress;
   logic [4:0]                StateOut;

   modport master (
      input  opcode, funct, overflowflag, zeroflag, gtflag, divby0flag, md_done,
      output PCWrite, IorD, WR, IRWrite, RegWrite, RegDest, MemToReg, ALUSrcA,
             ALUSrcB, ControlType, AluOutLoad, PCSource, EPCWrite, md_start,
             md_sel, ExceptionAdress, StateOut
   );

   modport slave (
      output opcode, funct, overflowflag, zeroflag, gtflag, divby0flag, md_done,
      input  PCWrite, IorD, WR, IRWrite, RegWrite, RegDest, MemToReg, ALUSrcA,
             ALUSrcB, ControlType, AluOutLoad, PCSource, EPCWrite, md_start,
             md_sel, ExceptionAdress, StateOut
   );
endinterface

// File: rtl/control_unit_fsm.sv
// Multicycle MIPS-subset control unit: fetch/decode/execute/memory/writeback
// sequencing with exception entry and a mult/div handshake.
module control_unit_fsm #(
   parameter int MEM_LATENCY    = 2,
   parameter int EXC_ADDR_WIDTH = 32,
   parameter int EXC_BASE       = 253
) (
   input  logic               clk,
   input  logic               reset_n,
   control_unit_fsm_if.master bus
);

   typedef enum logic [4:0] {
      S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_LUI,
      S_BRANCH, S_JUMP, S_JAL, S_JR, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_MD_START, S_MD_WAIT, S_RTE, S_BREAK, S_HALT, S_EXC, S_EXC_READ, S_EXC_JUMP
   } state_t;

   localparam logic [5:0] OP_R = 6'd0,  OP_J = 6'd2,  OP_JAL = 6'd3,  OP_BEQ = 6'd4;
   localparam logic [5:0] OP_BNE = 6'd5, OP_BLE = 6'd6, OP_BGT = 6'd7, OP_ADDI = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9, OP_LUI = 6'd15, OP_LW = 6'd35, OP_SW = 6'd43;
   localparam logic [5:0] FN_JR = 6'd8, FN_BREAK = 6'd13, FN_RTE = 6'd19, FN_MULT = 6'd24;
   localparam logic [5:0] FN_DIV = 6'd26, FN_ADD = 6'd32, FN_SUB = 6'd34, FN_AND = 6'd36;
   localparam logic [5:0] FN_SLT = 6'd42;

   localparam int CW = $clog2(MEM_LATENCY + 1) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY);

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [EXC_ADDR_WIDTH-1:0] exc_addr_q, exc_addr_d;
   logic [1:0]                exc_code;
   logic                      last_wait;

   assign last_wait = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_RESET;
         cnt_q      <= '0;
         exc_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         exc_addr_q <= exc_addr_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      exc_code         = 2'd0;
      bus.PCWrite      = 1'b0;
      bus.IorD         = 2'd0;
      bus.WR           = 1'b0;
      bus.IRWrite      = 1'b0;
      bus.RegWrite     = 1'b0;
      bus.RegDest      = 2'd0;
      bus.MemToReg     = 3'd0;
      bus.ALUSrcA      = 1'b0;
      bus.ALUSrcB      = 2'd0;
      bus.ControlType  = 3'd0;
      bus.AluOutLoad   = 1'b0;
      bus.PCSource     = 3'd0;
      bus.EPCWrite     = 1'b0;
      bus.md_start     = 1'b0;
      bus.md_sel       = 1'b0;
      // Gating on reset_n keeps pulses quiet in the cycle reset is first seen,
      // before the state register has been forced back to RESET.
      if (reset_n) begin
         unique case (state_q)
            S_RESET: begin
               bus.RegWrite = 1'b1;
               bus.RegDest  = 2'd3;
               bus.MemToReg = 3'd7;
               state_d      = S_FETCH;
            end
            S_FETCH: begin
               if (last_wait) begin
                  bus.IRWrite     = 1'b1;
                  bus.ALUSrcB     = 2'd1;
                  bus.ControlType = 3'd1;
                  bus.PCWrite     = 1'b1;
                  state_d         = S_DECODE;
               end
            end
            S_DECODE: begin
               bus.ALUSrcB     = 2'd3;
               bus.ControlType = 3'd1;
               bus.AluOutLoad  = 1'b1;
               state_d         = S_EXC;
               case (bus.opcode)
                  OP_R: begin
                     case (bus.funct)
                        FN_ADD, FN_SUB, FN_AND, FN_SLT: state_d = S_EXEC_R;
                        FN_JR:           state_d = S_JR;
                        FN_BREAK:        state_d = S_BREAK;
                        FN_RTE:          state_d = S_RTE;
                        FN_MULT, FN_DIV: state_d = S_MD_START;
                        default:         state_d = S_EXC;
                     endcase
                  end
                  OP_ADDI, OP_ADDIU:               state_d = S_EXEC_I;
                  OP_LUI:                          state_d = S_LUI;
                  OP_BEQ, OP_BNE, OP_BLE, OP_BGT:  state_d = S_BRANCH;
                  OP_LW, OP_SW:                    state_d = S_MEMADDR;
                  OP_J:                            state_d = S_JUMP;
                  OP_JAL:                          state_d = S_JAL;
                  default:                         state_d = S_EXC;
               endcase
            end
            S_EXEC_R: begin
               bus.ALUSrcA    = 1'b1;
               bus.AluOutLoad = 1'b1;
               case (bus.funct)
                  FN_SUB:  bus.ControlType = 3'd2;
                  FN_AND:  bus.ControlType = 3'd3;
                  FN_SLT:  bus.ControlType = 3'd7;
                  default: bus.ControlType = 3'd1;
               endcase
               if (bus.overflowflag && (bus.funct == FN_ADD || bus.funct == FN_SUB)) begin
                  exc_code = 2'd1;
                  state_d  = S_EXC;
               end else begin
                  state_d  = S_WB_R;
               end
            end
            S_WB_R: begin
               bus.RegWrite = 1'b1;
               bus.RegDest  = 2'd1;
               bus.MemToReg = (bus.funct == FN_SLT) ? 3'd4 : 3'd0;
               state_d      = S_FETCH;
            end
            S_EXEC_I: begin
               bus.ALUSrcA     = 1'b1;
               bus.ALUSrcB     = 2'd2;
               bus.ControlType = 3'd1;
               bus.AluOutLoad  = 1'b1;
               if (bus.overflowflag && bus.opcode == OP_ADDI) begin
                  exc_code = 2'd1;
                  state_d  = S_EXC;
               end else begin
                  state_d  = S_WB_I;
               end
            end
            S_WB_I: begin
               bus.RegWrite = 1'b1;
               state_d      = S_FETCH;
            end
            S_LUI: begin
               bus.RegWrite = 1'b1;
               bus.MemToReg = 3'd3;
               state_d      = S_FETCH;
            end
            S_BRANCH: begin
               bus.ALUSrcA     = 1'b1;
               bus.ControlType = 3'd2;
               bus.PCSource    = 3'd1;
               case (bus.opcode)
                  OP_BEQ:  bus.PCWrite = bus.zeroflag;
                  OP_BNE:  bus.PCWrite = !bus.zeroflag;
                  OP_BLE:  bus.PCWrite = !bus.gtflag;
                  default: bus.PCWrite = bus.gtflag;
               endcase
               state_d = S_FETCH;
            end
            S_JUMP: begin
               bus.PCSource = 3'd2;
               bus.PCWrite  = 1'b1;
               state_d      = S_FETCH;
            end
            S_JAL: begin
               bus.PCSource = 3'd2;
               bus.PCWrite  = 1'b1;
               bus.RegWrite = 1'b1;
               bus.RegDest  = 2'd2;
               bus.MemToReg = 3'd2;
               state_d      = S_FETCH;
            end
            S_JR: begin
               bus.PCSource = 3'd5;
               bus.PCWrite  = 1'b1;
               state_d      = S_FETCH;
            end
            S_RTE: begin
               bus.PCSource = 3'd4;
               bus.PCWrite  = 1'b1;
               state_d      = S_FETCH;
            end
            S_MEMADDR: begin
               bus.ALUSrcA     = 1'b1;
               bus.ALUSrcB     = 2'd2;
               bus.ControlType = 3'd1;
               bus.AluOutLoad  = 1'b1;
               state_d         = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
               bus.IorD = 2'd1;
               if (last_wait) begin
                  bus.IRWrite = 1'b1;
                  state_d     = S_MEMWB;
               end
            end
            S_MEMWB: begin
               bus.RegWrite = 1'b1;
               bus.MemToReg = 3'd1;
               state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
               bus.IorD = 2'd1;
               bus.WR   = 1'b1;
               state_d  = S_FETCH;
            end
            S_MD_START: begin
               bus.md_sel = (bus.funct == FN_DIV);
               if (bus.funct == FN_DIV && bus.divby0flag) begin
                  exc_code = 2'd2;
                  state_d  = S_EXC;
               end else begin
                  bus.md_start = 1'b1;
                  state_d      = S_MD_WAIT;
               end
            end
            S_MD_WAIT: begin
               if (bus.md_done) state_d = S_FETCH;
            end
            S_BREAK: begin
               bus.ALUSrcB     = 2'd1;
               bus.ControlType = 3'd2;
               bus.PCWrite     = 1'b1;
               state_d         = S_HALT;
            end
            S_HALT: state_d = S_HALT;
            S_EXC: begin
               bus.ALUSrcB     = 2'd1;
               bus.ControlType = 3'd2;
               bus.EPCWrite    = 1'b1;
               state_d         = S_EXC_READ;
            end
            S_EXC_READ: begin
               bus.IorD = 2'd2;
               if (last_wait) state_d = S_EXC_JUMP;
            end
            S_EXC_JUMP: begin
               bus.PCSource = 3'd3;
               bus.PCWrite  = 1'b1;
               state_d      = S_FETCH;
            end
            default: state_d = S_RESET;
         endcase
      end
   end

   // Handler address is captured on the transition into EXC so it is already
   // valid while EXC drives EPCWrite.
   always_comb begin
      exc_addr_d = exc_addr_q;
      if (state_q != S_EXC && state_d == S_EXC)
         exc_addr_d = EXC_ADDR_WIDTH'(EXC_BASE) + EXC_ADDR_WIDTH'(exc_code);
   end

   always_comb begin
      cnt_d = '0;
      if (state_d == state_q && cnt_q != CNT_LAST &&
          (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_EXC_READ))
         cnt_d = cnt_q + 1'b1;
   end

   assign bus.ExceptionAdress = exc_addr_q;
   assign bus.StateOut        = state_q;

endmodule
